// File: rtl/can_rx_deframer_if.sv
// Decoded-frame bus between the CAN receive deframer and its consumers
// (process state, UART logger).
//   frame_valid : one-cycle pulse when a complete frame is accepted
//   frame_id    : 11-bit identifier
//   frame_rtr   : RTR bit
//   frame_dlc   : raw DLC as received
//   frame_data  : data bytes, byte0 in [63:56], unused bytes zero
//   crc_ok      : received CRC matched, qualified by frame_valid
//   err_stuff   : one-cycle pulse on a stuff error
//   err_form    : one-cycle pulse on a form error
//   busy        : high from SOF until frame end or error
// master = deframer (drives the bus), slave = consumer.
interface can_rx_deframer_if;
  logic        frame_valid;
  logic [10:0] frame_id;
  logic        frame_rtr;
  logic [3:0]  frame_dlc;
  logic [63:0] frame_data;
  logic        crc_ok;
  logic        err_stuff;
  logic        err_form;
  logic        busy;

  modport master (
    output frame_valid, frame_id, frame_rtr, frame_dlc, frame_data,
           crc_ok, err_stuff, err_form, busy
  );

  modport slave (
    input  frame_valid, frame_id, frame_rtr, frame_dlc, frame_data,
           crc_ok, err_stuff, err_form, busy
  );
endinterface

// File: rtl/can_rx_deframer.sv
// CAN 2.0A receive deframer. Samples rx_bit on each bit_en strobe, removes
// stuff bits, parses a standard data/remote frame, checks CRC-15 and the
// fixed-form fields, and publishes the decoded frame with a one-cycle valid
// pulse. After any error it waits for IDLE_BITS recessive bits before it
// accepts another SOF.
// Ports:
//   can_clk : clock
//   reset   : synchronous, active-high
//   bit_en  : one-cycle strobe at the bit sample point
//   rx_bit  : bus level, 0 = dominant, 1 = recessive
//   frm     : decoded-frame bus (master side), see can_rx_deframer_if
module can_rx_deframer #(
  parameter int IDLE_BITS = 11,
  parameter int STUFF_EN  = 1
) (
  input  logic              can_clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              rx_bit,
  can_rx_deframer_if.master frm
);

  localparam int   REC_W    = $clog2(IDLE_BITS + 1);
  localparam logic STUFF_ON = (STUFF_EN != 0);

  typedef enum logic [3:0] {
    ST_SYNC, ST_IDLE, ST_ARB, ST_CTRL, ST_DATA,
    ST_CRC, ST_CRC_DEL, ST_ACK, ST_ACK_DEL, ST_EOF
  } state_t;

  // One CRC-15 step (poly 0x4599) for a single destuffed bit.
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    logic nxt;
    nxt = b ^ crc[14];
    crc15_step = {crc[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0000);
  endfunction

  state_t            state_r;
  logic [REC_W-1:0]  rec_cnt_r;
  logic [6:0]        bit_cnt_r;
  logic [14:0]       crc_r;
  logic [14:0]       rx_crc_r;
  logic              last_r;
  logic [2:0]        run_r;
  logic [11:0]       arb_sr_r;
  logic [3:0]        dlc_r;
  logic [6:0]        data_bits_r;
  logic [63:0]       data_sr_r;

  logic              frame_valid_r;
  logic [10:0]       frame_id_r;
  logic              frame_rtr_r;
  logic [3:0]        frame_dlc_r;
  logic [63:0]       frame_data_r;
  logic              crc_ok_r;
  logic              err_stuff_r;
  logic              err_form_r;
  logic              busy_r;

  logic              in_stuff_region_s;
  logic              stuff_bit_s;
  logic              stuff_err_s;
  logic [14:0]       crc_next_s;
  logic [3:0]        dlc_next_s;
  logic [3:0]        bytes_s;
  logic [6:0]        data_bits_s;

  // Stuff-bit detection, next CRC and data length for the current raw bit.
  always_comb begin
    in_stuff_region_s = 1'b0;
    case (state_r)
      ST_ARB, ST_CTRL, ST_DATA, ST_CRC, ST_CRC_DEL: in_stuff_region_s = 1'b1;
      default:                                     in_stuff_region_s = 1'b0;
    endcase
    // A pending stuff bit after the last CRC bit is still consumed in CRC_DEL.
    stuff_bit_s = STUFF_ON && in_stuff_region_s && (run_r == 3'd5);
    stuff_err_s = stuff_bit_s && (rx_bit == last_r);
    crc_next_s  = crc15_step(crc_r, rx_bit);
    dlc_next_s  = {dlc_r[2:0], rx_bit};
    if (arb_sr_r[0]) begin
      bytes_s = 4'd0;
    end else if (dlc_next_s > 4'd8) begin
      bytes_s = 4'd8;
    end else begin
      bytes_s = dlc_next_s;
    end
    data_bits_s = {bytes_s, 3'b000};
  end

  // Frame FSM: destuffing, field parsing, CRC and registered outputs.
  always_ff @(posedge can_clk) begin
    if (reset) begin
      state_r       <= ST_SYNC;
      rec_cnt_r     <= '0;
      bit_cnt_r     <= 7'd0;
      crc_r         <= 15'd0;
      rx_crc_r      <= 15'd0;
      last_r        <= 1'b0;
      run_r         <= 3'd0;
      arb_sr_r      <= 12'd0;
      dlc_r         <= 4'd0;
      data_bits_r   <= 7'd0;
      data_sr_r     <= 64'd0;
      frame_valid_r <= 1'b0;
      frame_id_r    <= 11'd0;
      frame_rtr_r   <= 1'b0;
      frame_dlc_r   <= 4'd0;
      frame_data_r  <= 64'd0;
      crc_ok_r      <= 1'b0;
      err_stuff_r   <= 1'b0;
      err_form_r    <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      frame_valid_r <= 1'b0;
      err_stuff_r   <= 1'b0;
      err_form_r    <= 1'b0;
      if (bit_en) begin
        if (stuff_bit_s) begin
          if (stuff_err_s) begin
            err_stuff_r <= 1'b1;
            busy_r      <= 1'b0;
            rec_cnt_r   <= '0;
            state_r     <= ST_SYNC;
          end else begin
            // Stuff bit is discarded but starts a new run.
            last_r <= rx_bit;
            run_r  <= 3'd1;
          end
        end else begin
          if (in_stuff_region_s && (state_r != ST_CRC_DEL)) begin
            run_r  <= (rx_bit == last_r) ? run_r + 3'd1 : 3'd1;
            last_r <= rx_bit;
          end
          case (state_r)
            ST_SYNC: begin
              if (rx_bit) begin
                if (rec_cnt_r == REC_W'(IDLE_BITS - 1)) begin
                  rec_cnt_r <= '0;
                  state_r   <= ST_IDLE;
                end else begin
                  rec_cnt_r <= rec_cnt_r + REC_W'(1);
                end
              end else begin
                rec_cnt_r <= '0;
              end
            end
            ST_IDLE: begin
              if (!rx_bit) begin
                busy_r    <= 1'b1;
                crc_r     <= 15'd0;
                last_r    <= 1'b0;
                run_r     <= 3'd1;
                bit_cnt_r <= 7'd0;
                data_sr_r <= 64'd0;
                state_r   <= ST_ARB;
              end
            end
            ST_ARB: begin
              crc_r    <= crc_next_s;
              arb_sr_r <= {arb_sr_r[10:0], rx_bit};
              if (bit_cnt_r == 7'd11) begin
                bit_cnt_r <= 7'd0;
                state_r   <= ST_CTRL;
              end else begin
                bit_cnt_r <= bit_cnt_r + 7'd1;
              end
            end
            ST_CTRL: begin
              crc_r <= crc_next_s;
              if ((bit_cnt_r == 7'd0) && rx_bit) begin
                // Extended frames (IDE = 1) are not supported.
                err_form_r <= 1'b1;
                busy_r     <= 1'b0;
                rec_cnt_r  <= '0;
                state_r    <= ST_SYNC;
              end else if (bit_cnt_r == 7'd5) begin
                dlc_r       <= dlc_next_s;
                data_bits_r <= data_bits_s;
                bit_cnt_r   <= 7'd0;
                state_r     <= (data_bits_s == 7'd0) ? ST_CRC : ST_DATA;
              end else begin
                if (bit_cnt_r >= 7'd2) begin
                  dlc_r <= dlc_next_s;
                end
                bit_cnt_r <= bit_cnt_r + 7'd1;
              end
            end
            ST_DATA: begin
              crc_r <= crc_next_s;
              data_sr_r[6'd63 - bit_cnt_r[5:0]] <= rx_bit;
              if (bit_cnt_r == data_bits_r - 7'd1) begin
                bit_cnt_r <= 7'd0;
                state_r   <= ST_CRC;
              end else begin
                bit_cnt_r <= bit_cnt_r + 7'd1;
              end
            end
            ST_CRC: begin
              rx_crc_r <= {rx_crc_r[13:0], rx_bit};
              if (bit_cnt_r == 7'd14) begin
                bit_cnt_r <= 7'd0;
                state_r   <= ST_CRC_DEL;
              end else begin
                bit_cnt_r <= bit_cnt_r + 7'd1;
              end
            end
            ST_CRC_DEL, ST_ACK_DEL: begin
              if (!rx_bit) begin
                err_form_r <= 1'b1;
                busy_r     <= 1'b0;
                rec_cnt_r  <= '0;
                state_r    <= ST_SYNC;
              end else begin
                bit_cnt_r <= 7'd0;
                state_r   <= (state_r == ST_CRC_DEL) ? ST_ACK : ST_EOF;
              end
            end
            ST_ACK: begin
              state_r <= ST_ACK_DEL;
            end
            ST_EOF: begin
              if (!rx_bit) begin
                err_form_r <= 1'b1;
                busy_r     <= 1'b0;
                rec_cnt_r  <= '0;
                state_r    <= ST_SYNC;
              end else if (bit_cnt_r == 7'd6) begin
                frame_valid_r <= 1'b1;
                crc_ok_r      <= (rx_crc_r == crc_r);
                frame_id_r    <= arb_sr_r[11:1];
                frame_rtr_r   <= arb_sr_r[0];
                frame_dlc_r   <= dlc_r;
                frame_data_r  <= data_sr_r;
                busy_r        <= 1'b0;
                state_r       <= ST_IDLE;
              end else begin
                bit_cnt_r <= bit_cnt_r + 7'd1;
              end
            end
            default: begin
              busy_r    <= 1'b0;
              rec_cnt_r <= '0;
              state_r   <= ST_SYNC;
            end
          endcase
        end
      end
    end
  end

  assign frm.frame_valid = frame_valid_r;
  assign frm.frame_id    = frame_id_r;
  assign frm.frame_rtr   = frame_rtr_r;
  assign frm.frame_dlc   = frame_dlc_r;
  assign frm.frame_data  = frame_data_r;
  assign frm.crc_ok      = crc_ok_r;
  assign frm.err_stuff   = err_stuff_r;
  assign frm.err_form    = err_form_r;
  assign frm.busy        = busy_r;

endmodule

// File: tb/tb_can_rx_deframer.sv
// Bench for can_rx_deframer: frames are encoded by a reference model
// (polynomial long-division CRC, bit stuffing over a queue), driven with
// fixed or random bit_en spacing, and the decoded result is compared with
// the fields the model encoded.
module tb_can_rx_deframer;
  logic can_clk = 1'b0;
  logic reset;
  logic bit_en;
  logic rx_bit;

  can_rx_deframer_if frm_if ();

  can_rx_deframer #(.IDLE_BITS(11), .STUFF_EN(1)) dut (
    .can_clk (can_clk),
    .reset   (reset),
    .bit_en  (bit_en),
    .rx_bit  (rx_bit),
    .frm     (frm_if)
  );

  always #5 can_clk = ~can_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- output monitor ----------------
  int cyc = 0;
  int last_en_cyc = -10;
  int n_valid = 0, n_estuff = 0, n_eform = 0;
  logic [10:0] cap_id;
  logic        cap_rtr;
  logic [3:0]  cap_dlc;
  logic [63:0] cap_data;
  logic        cap_crc_ok;
  logic        busy_after_sof;

  always @(posedge can_clk) begin
    cyc++;
    if (bit_en === 1'b1) last_en_cyc = cyc;
  end

  always @(negedge can_clk) begin
    if (frm_if.frame_valid === 1'b1) begin
      n_valid++;
      cap_id     = frm_if.frame_id;
      cap_rtr    = frm_if.frame_rtr;
      cap_dlc    = frm_if.frame_dlc;
      cap_data   = frm_if.frame_data;
      cap_crc_ok = frm_if.crc_ok;
      check_eq("valid_latency", 64'(cyc - last_en_cyc), 64'd0);
    end
    if (frm_if.err_stuff === 1'b1) n_estuff++;
    if (frm_if.err_form === 1'b1) n_eform++;
    if ((frm_if.err_stuff === 1'b1) || (frm_if.err_form === 1'b1)) begin
      check_eq("err_latency", 64'(cyc - last_en_cyc), 64'd0);
      check_eq("err_exclusive", 64'(frm_if.err_stuff & frm_if.err_form), 64'd0);
    end
  end

  // ---------------- reference model ----------------
  logic ds_q[$];   // destuffed bits SOF..CRC
  logic raw_q[$];  // bus bits including stuff bits and trailer

  // CRC as remainder of message * x^15 divided by x^15 + 0x4599.
  function automatic logic [14:0] crc15_ref();
    logic        m[$];
    logic [15:0] g;
    logic [14:0] r;
    g = 16'hC599;
    m = ds_q;
    for (int i = 0; i < 15; i++) m.push_back(1'b0);
    for (int i = 0; i + 16 <= m.size(); i++)
      if (m[i]) for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ g[15-j];
    for (int j = 0; j < 15; j++) r[14-j] = m[m.size()-15+j];
    return r;
  endfunction

  function automatic int nbytes(input logic rtr, input logic [3:0] dlc);
    if (rtr) return 0;
    return (dlc > 4'd8) ? 8 : int'(dlc);
  endfunction

  function automatic logic [63:0] exp_data(input logic rtr, input logic [3:0] dlc, input logic [63:0] d);
    logic [63:0] r;
    r = 64'd0;
    for (int k = 0; k < nbytes(rtr, dlc); k++) r[63-8*k -: 8] = d[63-8*k -: 8];
    return r;
  endfunction

  task automatic build_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                             input logic [63:0] d, input int crc_flip);
    logic [14:0] crc;
    int          run;
    logic        prev;
    ds_q = {};
    ds_q.push_back(1'b0);
    for (int i = 10; i >= 0; i--) ds_q.push_back(id[i]);
    ds_q.push_back(rtr);
    ds_q.push_back(1'b0);
    ds_q.push_back(1'b0);
    for (int i = 3; i >= 0; i--) ds_q.push_back(dlc[i]);
    for (int i = 0; i < nbytes(rtr, dlc) * 8; i++) ds_q.push_back(d[63-i]);
    crc = crc15_ref();
    if (crc_flip >= 0) crc[crc_flip] = ~crc[crc_flip];
    for (int i = 14; i >= 0; i--) ds_q.push_back(crc[i]);
    raw_q = {};
    run = 0;
    prev = 1'b1;
    foreach (ds_q[i]) begin
      raw_q.push_back(ds_q[i]);
      if (ds_q[i] == prev) run++;
      else begin run = 1; prev = ds_q[i]; end
      if (run == 5) begin raw_q.push_back(~prev); prev = ~prev; run = 1; end
    end
    raw_q.push_back(1'b1);                  // CRC delimiter
    raw_q.push_back(1'b0);                  // ACK (dominant)
    raw_q.push_back(1'b1);                  // ACK delimiter
    repeat (7) raw_q.push_back(1'b1);       // EOF
  endtask

  // ---------------- drivers ----------------
  // Entered and left at #1 after a rising edge.
  task automatic drive_bit(input logic b, input int gap);
    rx_bit = b;
    bit_en = 1'b1;
    @(posedge can_clk); #1;
    bit_en = 1'b0;
    for (int g = 0; g < gap; g++) begin
      rx_bit = 1'($urandom);
      @(posedge can_clk); #1;
    end
  endtask

  task automatic send_raw(input int gap_mode, input int upto);
    int n;
    n = (upto < 0) ? raw_q.size() : upto;
    for (int i = 0; i < n; i++) begin
      drive_bit(raw_q[i], (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode);
      if (i == 0) busy_after_sof = frm_if.busy;
    end
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1, 0);
  endtask

  task automatic verify(input string tag, input int v0, input int s0, input int f0,
                        input int dv, input int ds, input int df,
                        input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                        input logic [63:0] d, input logic crc_ok);
    repeat (2) @(posedge can_clk);
    #1;
    check_eq({tag, ":valid"}, 64'(n_valid - v0), 64'(dv));
    check_eq({tag, ":err_stuff"}, 64'(n_estuff - s0), 64'(ds));
    check_eq({tag, ":err_form"}, 64'(n_eform - f0), 64'(df));
    check_eq({tag, ":busy"}, 64'(frm_if.busy), 64'd0);
    if (dv == 1) begin
      check_eq({tag, ":id"}, 64'(cap_id), 64'(id));
      check_eq({tag, ":rtr"}, 64'(cap_rtr), 64'(rtr));
      check_eq({tag, ":dlc"}, 64'(cap_dlc), 64'(dlc));
      check_eq({tag, ":data"}, cap_data, exp_data(rtr, dlc, d));
      check_eq({tag, ":crc_ok"}, 64'(cap_crc_ok), 64'(crc_ok));
    end
  endtask

  task automatic run_frame(input string tag, input logic [10:0] id, input logic rtr,
                           input logic [3:0] dlc, input logic [63:0] d,
                           input int crc_flip, input int gap_mode);
    int v0, s0, f0;
    v0 = n_valid; s0 = n_estuff; f0 = n_eform;
    build_frame(id, rtr, dlc, d, crc_flip);
    send_raw(gap_mode, -1);
    verify(tag, v0, s0, f0, 1, 0, 0, id, rtr, dlc, d, 1'(crc_flip < 0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int v0, s0, f0;
    logic [10:0] rid;
    logic        rrtr;
    logic [3:0]  rdlc;
    logic [63:0] rdat;
    int          rflip;

    reset  = 1'b1;
    bit_en = 1'b0;
    rx_bit = 1'b1;
    repeat (3) @(posedge can_clk);
    #1;
    check_eq("rst:frame_valid", 64'(frm_if.frame_valid), 64'd0);
    check_eq("rst:frame_id", 64'(frm_if.frame_id), 64'd0);
    check_eq("rst:frame_rtr", 64'(frm_if.frame_rtr), 64'd0);
    check_eq("rst:frame_dlc", 64'(frm_if.frame_dlc), 64'd0);
    check_eq("rst:frame_data", frm_if.frame_data, 64'd0);
    check_eq("rst:crc_ok", 64'(frm_if.crc_ok), 64'd0);
    check_eq("rst:errs", 64'({frm_if.err_stuff, frm_if.err_form}), 64'd0);
    check_eq("rst:busy", 64'(frm_if.busy), 64'd0);
    reset = 1'b0;

    // Exactly IDLE_BITS recessive bits, then the basic frame.
    send_idle(11);
    run_frame("t1", 11'h123, 1'b0, 4'd1, 64'h8900_0000_0000_0000, -1, 0);
    check_eq("t1:busy_after_sof", 64'(busy_after_sof), 64'd1);

    // Same frame, one CRC bit inverted.
    send_idle(2);
    run_frame("t2", 11'h123, 1'b0, 4'd1, 64'h8900_0000_0000_0000, 7, 0);

    // Stuff error: the stuff bit after SOF + 4 zeros forced dominant.
    v0 = n_valid; s0 = n_estuff; f0 = n_eform;
    build_frame(11'h000, 1'b0, 4'd0, 64'd0, -1);
    raw_q[5] = 1'b0;
    send_raw(0, 6);
    verify("t3_stuff", v0, s0, f0, 0, 1, 0, 11'h000, 1'b0, 4'd0, 64'd0, 1'b0);
    // Immediate SOF must be ignored while resynchronising.
    v0 = n_valid; s0 = n_estuff; f0 = n_eform;
    build_frame(11'h2A5, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, -1);
    send_raw(0, -1);
    verify("t3_ignored", v0, s0, f0, 0, 0, 0, 11'h000, 1'b0, 4'd0, 64'd0, 1'b0);
    send_idle(11);
    run_frame("t3_after", 11'h2A5, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, -1, 1);

    // Form error on EOF bit 4: outputs keep the previous frame.
    v0 = n_valid; s0 = n_estuff; f0 = n_eform;
    build_frame(11'h555, 1'b0, 4'd3, 64'h1122_3300_0000_0000, -1);
    raw_q[raw_q.size() - 4] = 1'b0;
    send_raw(0, -1);
    verify("t4_eof", v0, s0, f0, 0, 0, 1, 11'h000, 1'b0, 4'd0, 64'd0, 1'b0);
    check_eq("t4:held_id", 64'(frm_if.frame_id), 64'h2A5);
    check_eq("t4:held_data", frm_if.frame_data, 64'hA55A_0000_0000_0000);
    send_idle(11);

    // DLC above 8 and a remote frame.
    run_frame("t5_dlcF", 11'h7FF, 1'b0, 4'hF, 64'h0102_0304_0506_0708, -1, 0);
    run_frame("t5_rtr", 11'h0F0, 1'b1, 4'd2, 64'hDEAD_BEEF_0000_0000, -1, 0);

    // Reset in the middle of DATA.
    v0 = n_valid; s0 = n_estuff; f0 = n_eform;
    build_frame(11'h3C3, 1'b0, 4'd4, 64'hCAFE_F00D_0000_0000, -1);
    send_raw(0, 28);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) drive_bit(1'($urandom), 0);
    reset = 1'b0;
    check_eq("t6:no_pulses", 64'((n_valid - v0) + (n_estuff - s0) + (n_eform - f0)), 64'd0);
    check_eq("t6:id_cleared", 64'(frm_if.frame_id), 64'd0);
    check_eq("t6:busy_cleared", 64'(frm_if.busy), 64'd0);
    send_idle(11);
    run_frame("t6_gap3", 11'h3C3, 1'b0, 4'd4, 64'hCAFE_F00D_0000_0000, -1, 3);
    run_frame("t6_gap0", 11'h4B1, 1'b0, 4'd8, 64'h1357_9BDF_0246_8ACE, -1, 0);

    // Randomised frames, random strobe spacing, some corrupted CRCs.
    for (int n = 0; n < 24; n++) begin
      rid   = 11'($urandom);
      rrtr  = ($urandom_range(0, 3) == 0);
      rdlc  = 4'($urandom);
      rdat  = {$urandom, $urandom};
      rflip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1;
      send_idle(int'($urandom_range(0, 3)));
      run_frame("rand", rid, rrtr, rdlc, rdat, rflip, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/can_rx_deframer.md
Name: can_rx_deframer

Overview:
- Receive-side stage that sits downstream of the CAN bus pins of the CAN node.
- Samples the bus one bit per bit_en strobe and removes stuff bits.
- Parses a CAN 2.0A standard data/remote frame, checks CRC-15 and the fixed-form fields, and presents the decoded frame with a one-cycle valid pulse to the node's process state and UART logger.
- Error conditions are flagged, and the block re-synchronises to bus idle after an error.

Parameters:
- IDLE_BITS, 11, consecutive recessive bits required before a SOF is accepted (after reset or error).
- STUFF_EN, 1, 1 = destuff and check stuffing; 0 = no stuff bits expected (for the current unstuffed transmitter).

Ports:
- can_clk  input  1  single clock.
- reset  input  1  synchronous, active-high.
- bit_en  input  1  one-cycle strobe at the bit sample point; rx_bit is sampled only when high.
- rx_bit  input  1  bus level, same sense as can_lo_in: 0 = dominant, 1 = recessive.
- frame_valid  output  1  one-cycle pulse when a complete frame is accepted.
- frame_id  output  11  identifier.
- frame_rtr  output  1  RTR bit.
- frame_dlc  output  4  raw DLC as received.
- frame_data  output  64  data bytes; byte0 in [63:56]; unused bytes 0.
- crc_ok  output  1  received CRC equals computed CRC; valid when frame_valid is high.
- err_stuff  output  1  one-cycle pulse on a stuff error.
- err_form  output  1  one-cycle pulse on a form error.
- busy  output  1  high from SOF until frame end or error.

Behaviour:
- Reset: every output is 0; state = SYNC; recessive counter = 0; CRC register = 0. Reset mid-frame discards the partial frame without flagging an error.
- All state advances only on cycles with bit_en = 1. With bit_en = 0, all state holds; back-to-back bit_en on consecutive cycles is legal.
- SYNC: count consecutive recessive bits; a dominant bit clears the count. At IDLE_BITS, go to IDLE.
- IDLE: dominant bit = SOF; set busy, clear CRC, seed the stuff tracker with last = 0, run = 1, then go to ARB.
- ARB: 12 destuffed bits, ID MSB first, then RTR.
- CTRL: IDE, r0, then 4 DLC bits MSB first.
  - IDE = 1 is unsupported: err_form, go to SYNC.
  - Data byte count = 0 if RTR = 1, else min(DLC, 8).
  - Count 0: go to CRC, else DATA.
- DATA: byte-count × 8 bits, MSB first; byte k fills frame_data[63-8k -: 8].
- CRC: 15 bits, MSB first, captured into the received-CRC register.
- CRC-15, polynomial 0x4599, register init 0. Updated per destuffed bit from SOF through the last data bit: nxt = bit XOR crc[14]; crc = {crc[13:0], 0} XOR (nxt ? 0x4599 : 0).
- Stuffing (STUFF_EN = 1): applies from SOF through the last CRC bit.
  - Track the run of identical raw bits. After 5 identical bits, the next raw bit is a stuff bit: it is discarded and not fed to the CRC or parser.
  - If the stuff bit equals the previous bit: err_stuff, go to SYNC.
  - The stuff bit counts as the first bit of a new run.
  - A stuff bit may follow the last CRC bit and must be consumed before CRC_DEL.
- CRC_DEL: must be recessive, else err_form.
- ACK: either level accepted.
- ACK_DEL: must be recessive, else err_form.
- EOF: 7 recessive bits; any dominant bit gives err_form.
- After the 7th EOF bit:
  - Next can_clk cycle: frame_valid = 1 for one cycle, crc_ok = (rx_crc == computed crc), busy = 0.
  - frame_id, frame_rtr, frame_dlc and frame_data update on that same cycle and hold until the next frame_valid.
  - State goes to IDLE (intermission is not enforced; the next dominant bit is a SOF).
- Any error: a one-cycle pulse on the cycle after the offending bit; busy = 0; frame outputs unchanged; state = SYNC, so IDLE_BITS recessive bits are needed before the next SOF. err_stuff and err_form never pulse together; stuff is checked first.
- STUFF_EN = 0: no stuff tracking and err_stuff never asserts; field parsing is otherwise identical.

Test Plan:
- Reset, 11 recessive, then stuffed frame ID 0x123, RTR 0, DLC 1, data 0x89, model-computed CRC, 3 recessive delim/ack/delim (ACK dominant), 7 recessive EOF -> single frame_valid pulse; frame_id = 0x123, frame_dlc = 1, frame_data = 0x8900000000000000, crc_ok = 1, no errors.
- Same frame with one CRC bit inverted (stuffing recomputed) -> frame_valid, crc_ok = 0, data still 0x89.
- Frame with ID 0x000 and the stuff bit after SOF plus 4 ID zeros replaced by dominant -> err_stuff pulse, no frame_valid. An immediate SOF is ignored; after 11 recessive, a valid frame is accepted.
- Valid frame with EOF bit 4 dominant -> err_form pulse, frame outputs retain the previous frame.
- DLC = 0xF with 8 data bytes 0x01..0x08 -> frame_dlc = 0xF, frame_data = 0x0102030405060708, crc_ok = 1. Also RTR = 1, DLC = 2 with no data -> frame_rtr = 1, frame_data = 0.
- reset asserted mid-DATA, then a valid frame with bit_en every 4th cycle and then every cycle -> no pulses during reset; both frames decode correctly, timing independent of strobe spacing.
